// File: rtl/quiz_round_ctrl_if.sv
// Signal bundle between the quiz round controller and its surroundings
// (player inputs, question decoder, score block).
interface quiz_round_ctrl_if;
  logic       start;
  logic       buzz_p1;
  logic       buzz_p2;
  logic [3:0] ans_in;
  logic       ans_submit;
  logic [3:0] bcd_ans;
  logic       win_in;
  logic [3:0] bcd_state;
  logic       tog_score_p1;
  logic       tog_score_p2;
  logic [1:0] owner;
  logic       answer_ok;
  logic       answer_bad;
  logic       game_over;

  // Environment side: drives player/decoder/score inputs, observes results
  modport master (
    output start, buzz_p1, buzz_p2, ans_in, ans_submit, bcd_ans, win_in,
    input  bcd_state, tog_score_p1, tog_score_p2, owner, answer_ok,
           answer_bad, game_over
  );

  // Controller side
  modport slave (
    input  start, buzz_p1, buzz_p2, ans_in, ans_submit, bcd_ans, win_in,
    output bcd_state, tog_score_p1, tog_score_p2, owner, answer_ok,
           answer_bad, game_over
  );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Round controller for the two-player buzzer quiz: steps the question index,
// arbitrates buzzers, judges answers and emits one-cycle score pulses.
module quiz_round_ctrl #(
  parameter int unsigned ANSWER_TIMEOUT = 200,
  parameter int unsigned LAST_Q         = 9
) (
  input logic              clk,
  input logic              rst_n,
  quiz_round_ctrl_if.slave bus
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned Q_W     = 4;
  localparam logic [1:0]  OWN_NONE = 2'b00;
  localparam logic [1:0]  OWN_P1   = 2'b01;
  localparam logic [1:0]  OWN_P2   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASK,
    S_ANSWER,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state;
  logic               start_q, buzz1_q, buzz2_q, submit_q;
  logic [1:0]         lock;      // bit0 = P1 locked out, bit1 = P2 locked out
  logic               tie_pri;   // 0 = P1 wins next tie, 1 = P2
  logic [TIMER_W-1:0] timer;
  logic [Q_W-1:0]     bcd_state_q;
  logic [1:0]         owner_q;
  logic               tog_p1_q, tog_p2_q, ok_q, bad_q, over_q;

  logic start_ev, buzz1_ev, buzz2_ev, submit_ev;
  logic buzz1_ok, buzz2_ok, ans_match;

  assign start_ev  = bus.start      & ~start_q;
  assign buzz1_ev  = bus.buzz_p1    & ~buzz1_q;
  assign buzz2_ev  = bus.buzz_p2    & ~buzz2_q;
  assign submit_ev = bus.ans_submit & ~submit_q;
  assign buzz1_ok  = buzz1_ev & ~lock[0];
  assign buzz2_ok  = buzz2_ev & ~lock[1];
  assign ans_match = (bus.ans_in == bus.bcd_ans);

  // Previous-sample registers for rising-edge event detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      buzz1_q  <= 1'b0;
      buzz2_q  <= 1'b0;
      submit_q <= 1'b0;
    end else begin
      start_q  <= bus.start;
      buzz1_q  <= bus.buzz_p1;
      buzz2_q  <= bus.buzz_p2;
      submit_q <= bus.ans_submit;
    end
  end

  // Round state machine with registered outputs; pulses default low each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lock        <= 2'b00;
      tie_pri     <= 1'b0;
      timer       <= '0;
      bcd_state_q <= '0;
      owner_q     <= OWN_NONE;
      tog_p1_q    <= 1'b0;
      tog_p2_q    <= 1'b0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      tog_p1_q <= 1'b0;
      tog_p2_q <= 1'b0;
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          bcd_state_q <= '0;
          owner_q     <= OWN_NONE;
          lock        <= 2'b00;
          if (start_ev) state <= S_ASK;
        end

        S_ASK: begin
          if (bus.win_in) begin
            state  <= S_DONE;
            over_q <= 1'b1;
          end else if (buzz1_ok || buzz2_ok) begin
            // Tie priority only rotates when it actually decided a tie
            if (buzz1_ok && buzz2_ok) begin
              owner_q <= tie_pri ? OWN_P2 : OWN_P1;
              tie_pri <= ~tie_pri;
            end else begin
              owner_q <= buzz1_ok ? OWN_P1 : OWN_P2;
            end
            timer <= TIMER_W'(ANSWER_TIMEOUT);
            state <= S_ANSWER;
          end
        end

        S_ANSWER: begin
          // Timer value 1 at an edge means it reaches 0 on this edge
          if (submit_ev && ans_match) begin
            ok_q     <= 1'b1;
            tog_p1_q <= owner_q[0];
            tog_p2_q <= owner_q[1];
            timer    <= '0;
            state    <= S_NEXT;
          end else if (submit_ev || (timer <= TIMER_W'(1))) begin
            bad_q   <= 1'b1;
            lock    <= lock | owner_q;
            owner_q <= OWN_NONE;
            timer   <= '0;
            state   <= S_CHECK;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        S_CHECK: begin
          state <= (&lock) ? S_NEXT : S_ASK;
        end

        S_NEXT: begin
          lock    <= 2'b00;
          owner_q <= OWN_NONE;
          if (bus.win_in || (bcd_state_q == Q_W'(LAST_Q))) begin
            state  <= S_DONE;
            over_q <= 1'b1;
          end else begin
            bcd_state_q <= bcd_state_q + Q_W'(1);
            state       <= S_ASK;
          end
        end

        S_DONE: begin
          if (start_ev) begin
            state       <= S_IDLE;
            over_q      <= 1'b0;
            bcd_state_q <= '0;
            owner_q     <= OWN_NONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.bcd_state    = bcd_state_q;
  assign bus.owner        = owner_q;
  assign bus.tog_score_p1 = tog_p1_q;
  assign bus.tog_score_p2 = tog_p2_q;
  assign bus.answer_ok    = ok_q;
  assign bus.answer_bad   = bad_q;
  assign bus.game_over    = over_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with a 5-cycle answer timeout.
`timescale 1ns/1ps
module tb_quiz_round_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  quiz_round_ctrl_if bus ();

  quiz_round_ctrl #(
    .ANSWER_TIMEOUT(5),
    .LAST_Q        (9)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // P1 buzzes and answers correctly; exp_bcd is the index after NEXT
  task automatic quick_round(input logic [3:0] exp_bcd);
    bus.bcd_ans = 4'd0;
    bus.ans_in  = 4'd0;
    bus.buzz_p1 = 1'b1;
    step(1);
    check("quick_owner", 8'(bus.owner), 8'h1);
    bus.buzz_p1    = 1'b0;
    bus.ans_submit = 1'b1;
    step(1);
    check("quick_ok", 8'(bus.answer_ok), 8'h1);
    bus.ans_submit = 1'b0;
    step(1);
    check("quick_bcd", 8'(bus.bcd_state), 8'(exp_bcd));
  endtask

  // Both players buzz on the same edge, winner answers correctly
  task automatic tie_round(input logic [1:0] exp_owner, input logic [3:0] exp_bcd);
    bus.bcd_ans = 4'd7;
    bus.ans_in  = 4'd7;
    bus.buzz_p1 = 1'b1;
    bus.buzz_p2 = 1'b1;
    step(1);
    check("tie_owner", 8'(bus.owner), 8'(exp_owner));
    bus.buzz_p1    = 1'b0;
    bus.buzz_p2    = 1'b0;
    bus.ans_submit = 1'b1;
    step(1);
    check("tie_tog_p1", 8'(bus.tog_score_p1), 8'(exp_owner[0]));
    check("tie_tog_p2", 8'(bus.tog_score_p2), 8'(exp_owner[1]));
    bus.ans_submit = 1'b0;
    step(1);
    check("tie_bcd", 8'(bus.bcd_state), 8'(exp_bcd));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.buzz_p1    = 1'b0;
    bus.buzz_p2    = 1'b0;
    bus.ans_in     = 4'd0;
    bus.ans_submit = 1'b0;
    bus.bcd_ans    = 4'd0;
    bus.win_in     = 1'b0;
    step(2);
    check("rst_bcd", 8'(bus.bcd_state), 8'h0);
    check("rst_owner", 8'(bus.owner), 8'h0);
    check("rst_over", 8'(bus.game_over), 8'h0);
    rst_n = 1'b1;
    step(1);

    // Correct answer by P1 on question 0
    bus.start = 1'b1;
    step(1);
    check("start_bcd", 8'(bus.bcd_state), 8'h0);
    bus.bcd_ans = 4'd1;
    bus.ans_in  = 4'd1;
    bus.buzz_p1 = 1'b1;
    step(1);
    check("c_owner", 8'(bus.owner), 8'h1);
    bus.buzz_p1    = 1'b0;
    bus.ans_submit = 1'b1;
    step(1);
    check("c_ok", 8'(bus.answer_ok), 8'h1);
    check("c_tog_p1", 8'(bus.tog_score_p1), 8'h1);
    check("c_tog_p2", 8'(bus.tog_score_p2), 8'h0);
    check("c_bcd_hold", 8'(bus.bcd_state), 8'h0);
    bus.ans_submit = 1'b0;
    step(1);
    check("c_ok_end", 8'(bus.answer_ok), 8'h0);
    check("c_tog_end", 8'(bus.tog_score_p1), 8'h0);
    check("c_bcd", 8'(bus.bcd_state), 8'h1);
    check("c_owner_clr", 8'(bus.owner), 8'h0);

    // Wrong answer by P1 hands question 1 to P2
    bus.bcd_ans = 4'd2;
    bus.ans_in  = 4'd3;
    bus.buzz_p1 = 1'b1;
    step(1);
    check("w_owner", 8'(bus.owner), 8'h1);
    bus.buzz_p1    = 1'b0;
    bus.ans_submit = 1'b1;
    step(1);
    check("w_bad", 8'(bus.answer_bad), 8'h1);
    check("w_ok", 8'(bus.answer_ok), 8'h0);
    check("w_owner_clr", 8'(bus.owner), 8'h0);
    bus.ans_submit = 1'b0;
    step(1);
    bus.buzz_p1 = 1'b1;
    step(1);
    check("w_locked_p1", 8'(bus.owner), 8'h0);
    bus.buzz_p1 = 1'b0;
    bus.buzz_p2 = 1'b1;
    step(1);
    check("w_owner_p2", 8'(bus.owner), 8'h2);
    bus.buzz_p2    = 1'b0;
    bus.ans_in     = 4'd2;
    bus.ans_submit = 1'b1;
    step(1);
    check("w_tog_p2", 8'(bus.tog_score_p2), 8'h1);
    check("w_tog_p1", 8'(bus.tog_score_p1), 8'h0);
    bus.ans_submit = 1'b0;
    step(1);
    check("w_bcd", 8'(bus.bcd_state), 8'h2);

    // Both players time out on question 2
    bus.buzz_p1 = 1'b1;
    step(1);
    check("t_owner_p1", 8'(bus.owner), 8'h1);
    bus.buzz_p1 = 1'b0;
    step(4);
    check("t_p1_early", 8'(bus.answer_bad), 8'h0);
    check("t_p1_still", 8'(bus.owner), 8'h1);
    step(1);
    check("t_p1_bad", 8'(bus.answer_bad), 8'h1);
    step(1);
    bus.buzz_p2 = 1'b1;
    step(1);
    check("t_owner_p2", 8'(bus.owner), 8'h2);
    bus.buzz_p2 = 1'b0;
    step(4);
    check("t_p2_early", 8'(bus.answer_bad), 8'h0);
    step(1);
    check("t_p2_bad", 8'(bus.answer_bad), 8'h1);
    check("t_p2_notog", 8'(bus.tog_score_p2), 8'h0);
    step(1);
    check("t_check_bcd", 8'(bus.bcd_state), 8'h2);
    step(1);
    check("t_next_bcd", 8'(bus.bcd_state), 8'h3);
    check("t_next_tog1", 8'(bus.tog_score_p1), 8'h0);
    check("t_next_tog2", 8'(bus.tog_score_p2), 8'h0);

    // Ties alternate P1, P2, P1
    tie_round(2'b01, 4'd4);
    tie_round(2'b10, 4'd5);
    tie_round(2'b01, 4'd6);

    // Play through to the last question
    quick_round(4'd7);
    quick_round(4'd8);
    quick_round(4'd9);
    quick_round(4'd9);
    check("end_over", 8'(bus.game_over), 8'h1);
    bus.buzz_p1 = 1'b1;
    step(2);
    check("end_bcd_hold", 8'(bus.bcd_state), 8'h9);
    check("end_no_owner", 8'(bus.owner), 8'h0);
    bus.buzz_p1 = 1'b0;

    // Start from DONE returns to IDLE
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    check("idle_bcd", 8'(bus.bcd_state), 8'h0);
    check("idle_over", 8'(bus.game_over), 8'h0);

    // New game, win flag in ASK at question 4
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    quick_round(4'd1);
    quick_round(4'd2);
    quick_round(4'd3);
    quick_round(4'd4);
    bus.win_in = 1'b1;
    step(1);
    check("win_over", 8'(bus.game_over), 8'h1);
    check("win_bcd", 8'(bus.bcd_state), 8'h4);
    bus.win_in = 1'b0;

    // Asynchronous reset during ANSWER
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    quick_round(4'd1);
    bus.buzz_p1 = 1'b1;
    step(1);
    check("ar_owner_pre", 8'(bus.owner), 8'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_owner", 8'(bus.owner), 8'h0);
    check("ar_bcd", 8'(bus.bcd_state), 8'h0);
    check("ar_over", 8'(bus.game_over), 8'h0);
    bus.start = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1);
    check("rel_owner", 8'(bus.owner), 8'h0);
    step(1);
    check("rel_owner2", 8'(bus.owner), 8'h0);
    bus.start = 1'b1;
    step(1);
    check("rel_ask_owner", 8'(bus.owner), 8'h0);
    bus.buzz_p1 = 1'b0;
    step(1);
    bus.buzz_p1 = 1'b1;
    step(1);
    check("rel_buzz", 8'(bus.owner), 8'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round controller for the two-player buzzer quiz. It is the stage directly upstream of the question decoder and the score counters. It advances the question index `bcd_state` (0..9) and arbitrates the two buzzers. It checks each submitted BCD answer against the decoder's `bcd_ans` and emits one-cycle score pulses on `tog_score_p1`/`tog_score_p2`, which the score counters count on their rising edge. It stops the game after question 9 or when a player reaches the winning score.

## Interface
- `ANSWER_TIMEOUT`, default 200: cycles allowed between buzz-in and submit; range 1..65535.
- `LAST_Q`, default 9: index of the final question.
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level, synchronous to `clk`; rising edge starts or restarts a game.
- `buzz_p1`, `buzz_p2` in 1: debounced buzzer levels; the rising edge is the buzz event.
- `ans_in` in 4: BCD answer from the answering player's switches.
- `ans_submit` in 1: level; the rising edge is the submit event.
- `bcd_ans` in 4: correct answer for the current question, from the question decoder.
- `win_in` in 1: high when either score is at least 5; comes from the score block's beep flag.
- `bcd_state` out 4: current question index, fed to the question decoder.
- `tog_score_p1`, `tog_score_p2` out 1: one-cycle score pulses.
- `owner` out 2: current answering player; 00 = none, 01 = P1, 10 = P2.
- `answer_ok`, `answer_bad` out 1: one-cycle verdict pulses, for beep or LED use.
- `game_over` out 1: high while the controller is in DONE.

## Operation
- Edge detect:
  - Each of `start`, `buzz_p1`, `buzz_p2` and `ans_submit` has a previous-sample register.
  - An event occurs at the edge where the input is 1 and its previous sample is 0.
  - All previous-sample registers reset to 0, so an input held high through reset fires an event at the first edge after reset.
- States:
  - IDLE:
    - `bcd_state`=0, `owner`=00.
    - A start event goes to ASK.
- ASK, waiting for a buzz. A buzz is only accepted from a player who is not locked out.
  - If `win_in`=1, go to DONE. This check has priority over buzzes.
  - A single buzz sets `owner` to that player, loads the timer with `ANSWER_TIMEOUT` and goes to ANSWER.
  - If both players buzz on the same edge and both are eligible, the tie goes to `tie_pri`.
    - `tie_pri` is a 1-bit register that resets to P1.
    - It flips to the other player after each tie it decides.
  - If only one of the tied players is eligible, that player wins the tie and `tie_pri` does not change.
- ANSWER:
  - The timer decrements every cycle.
  - On a submit event:
    - If `ans_in` == `bcd_ans`: pulse `answer_ok` and the owner's `tog_score_*`, then go to NEXT.
    - Otherwise: pulse `answer_bad`, set the owner's lockout bit, clear `owner` and go to CHECK.
  - On timeout (the timer reaches 0 with no submit): treated exactly as a wrong answer.
  - A submit event on the same edge as the timeout wins.
  - Buzz events during ANSWER are ignored.
- CHECK, one cycle:
  - If both lockout bits are set, go to NEXT. Otherwise go to ASK, where only the other player is eligible.
- NEXT, one cycle:
  - Clear both lockout bits and clear `owner`.
  - If `win_in`=1 or `bcd_state`==`LAST_Q`, go to DONE.
  - Otherwise increment `bcd_state` and go to ASK.
- DONE:
  - `game_over`=1 and `bcd_state` holds its value.
  - A start event goes to IDLE.
- Start event outside IDLE and DONE: ignored.
- This block never clears the score counters; that is the responsibility of the score block.

## Timing
- Reset (async assert): every output is 0 (`bcd_state`=0, `owner`=00, all pulses 0, `game_over`=0).
  - Internal state after reset: state IDLE, lockouts clear, `tie_pri`=P1, timer 0.
- All outputs are registered and change only on a `clk` rising edge.
- Buzz latency: a buzz event at edge k means `owner` is valid after edge k.
- Submit latency: a submit event at edge k means the `answer_ok`/`answer_bad` and `tog_score_*` pulses are high for exactly the cycle after edge k.
  - The pulse is followed by NEXT at edge k+1; `bcd_state` increments at edge k+1.
  - `win_in` therefore has one full cycle to settle after the `tog_score` rising edge before NEXT samples it.
- Timeout: ANSWER entered at edge t with no submit means the timeout verdict occurs at edge t+`ANSWER_TIMEOUT`.
- Timer width: 16 bits.
- `bcd_state` never exceeds `LAST_Q` and never wraps.

## Test plan
- Correct answer:
  - Stimulus: reset, start, `buzz_p1` rises, `ans_in`=1 with `bcd_ans`=1, submit.
  - Required: `owner`=01; one-cycle `tog_score_p1` and `answer_ok`; `bcd_state` 0→1; `tog_score_p2` stays 0.
- Wrong answer hands off to the other player:
  - Stimulus: P1 buzzes and submits 3 with `bcd_ans`=2.
  - Required: `answer_bad` pulse; a further P1 buzz is ignored; P2 buzzes and submits 2.
  - Required result: `tog_score_p2` pulse, then `bcd_state` advances.
- Timeout on both players, with `ANSWER_TIMEOUT`=5:
  - Stimulus: P1 buzzes and never submits.
  - Required: `answer_bad` at buzz+5 cycles.
  - Stimulus: P2 then buzzes and also times out.
  - Required: NEXT, `bcd_state` increments, no score pulse.
- Ties:
  - Stimulus: `buzz_p1` and `buzz_p2` rise on the same edge, three times in separate questions.
  - Required: `owner` goes 01, 10, 01.
- End of game:
  - Stimulus: reach `bcd_state`=9 and answer correctly.
  - Required: `game_over`=1 and `bcd_state` holds 9.
  - Stimulus: `win_in`=1 while in ASK at question 4.
  - Required: DONE on the next edge.
  - Stimulus: start event from DONE.
  - Required: IDLE with `bcd_state`=0.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 asynchronously during ANSWER.
  - Required: all outputs 0 immediately, without waiting for a `clk` edge.
  - Stimulus: release reset with `buzz_p1` held high.
  - Required: IDLE; the buzz is ignored until a start event.
